// File: rtl/popo_bus_pkg.sv
// Shared definitions for the cache burst bus memory responder: FSM states,
// arbitration priority encoding, byte-to-word offset and default burst lengths.
package popo_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    WR_RESP  = 2'd3
  } resp_state_t;

  // Which side wins when read and write requests collide in IDLE.
  typedef enum logic {
    PRI_READ  = 1'b0,
    PRI_WRITE = 1'b1
  } rr_pri_t;

  // Addresses are byte addresses; words are 4 bytes.
  localparam int WORD_OFFSET = 2;

  localparam int DEFAULT_READ_BURST_LEN  = 8;
  localparam int DEFAULT_WRITE_BURST_LEN = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word array behind the burst responder: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module word_ram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    NUM_WORDS  = 128,
  parameter string INIT_FILE  = "",
  localparam int   IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  // Single write port, one word per clock.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the cache burst read/write bus. Serves one burst
// at a time from a word array: reads stream READ_BURST_LEN registered beats,
// writes absorb WRITE_BURST_LEN beats and then return a response that flags
// a misplaced wr_data_last. Read/write collisions are arbitrated round-robin.
module burst_mem_responder
  import popo_bus_pkg::*;
#(
  parameter int    DATA_WIDTH      = 32,
  parameter int    ADDR_WIDTH      = 32,
  parameter int    NUM_WORDS       = 128,
  parameter int    READ_BURST_LEN  = DEFAULT_READ_BURST_LEN,
  parameter int    WRITE_BURST_LEN = DEFAULT_WRITE_BURST_LEN,
  parameter string INIT_FILE       = ""
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_last,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_last,
  output logic                  wr_resp_valid,
  input  logic                  wr_resp_ready,
  output logic                  wr_resp_err
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  // One spare bit so the counter can hold the burst length without wrapping.
  localparam int BEAT_W = $clog2(max_int(READ_BURST_LEN, WRITE_BURST_LEN)) + 1;

  localparam logic [BEAT_W-1:0] RD_LAST_BEAT   = BEAT_W'(READ_BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] WR_LAST_BEAT   = BEAT_W'(WRITE_BURST_LEN - 1);
  localparam logic              RD_SINGLE_BEAT = (READ_BURST_LEN == 1);

  resp_state_t      state;
  resp_state_t      next_state;
  rr_pri_t          rr_pri;
  logic [IDX_W-1:0] idx;
  logic [BEAT_W-1:0] beat;
  logic             err;

  logic [IDX_W-1:0]      rd_req_idx;
  logic [IDX_W-1:0]      wr_req_idx;
  logic                  grant_rd;
  logic                  grant_wr;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  rd_beat_hs;
  logic                  wr_beat_hs;
  logic                  rd_at_last;
  logic                  wr_at_last;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Only the word-index slice of each address matters; the remaining bits
  // (byte lane and upper address) are intentionally dropped here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_req_addr, wr_req_addr};

  assign rd_req_idx = rd_req_addr[WORD_OFFSET +: IDX_W];
  assign wr_req_idx = wr_req_addr[WORD_OFFSET +: IDX_W];

  // A lone request always wins; on a collision rr_pri decides.
  assign grant_rd = rd_req_valid & (~wr_req_valid | (rr_pri == PRI_READ));
  assign grant_wr = wr_req_valid & (~rd_req_valid | (rr_pri == PRI_WRITE));

  assign rd_accept  = rd_req_valid & rd_req_ready;
  assign wr_accept  = wr_req_valid & wr_req_ready;
  assign rd_beat_hs = rd_data_valid & rd_data_ready;
  assign wr_beat_hs = wr_data_valid & wr_data_ready;
  assign rd_at_last = (beat == RD_LAST_BEAT);
  assign wr_at_last = (beat == WR_LAST_BEAT);

  word_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_word_ram (
    .clk   (sys_clk),
    .we    (mem_we),
    .waddr (idx),
    .wdata (wr_data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the handshake outputs that follow the state.
  always_comb begin
    next_state    = state;
    rd_req_ready  = 1'b0;
    wr_req_ready  = 1'b0;
    wr_data_ready = 1'b0;
    wr_resp_valid = 1'b0;
    wr_resp_err   = 1'b0;
    mem_we        = 1'b0;
    mem_raddr     = idx;
    case (state)
      IDLE: begin
        rd_req_ready = grant_rd;
        wr_req_ready = grant_wr;
        // Look up beat 0 directly from the request so it registers on accept.
        mem_raddr    = rd_req_idx;
        if (grant_rd) begin
          next_state = RD_BURST;
        end else if (grant_wr) begin
          next_state = WR_BURST;
        end
      end
      RD_BURST: begin
        if (rd_beat_hs && rd_at_last) begin
          next_state = IDLE;
        end
      end
      WR_BURST: begin
        wr_data_ready = 1'b1;
        mem_we        = wr_data_valid;
        if (wr_data_valid && wr_at_last) begin
          next_state = WR_RESP;
        end
      end
      WR_RESP: begin
        wr_resp_valid = 1'b1;
        wr_resp_err   = err;
        if (wr_resp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Round-robin priority flips only when both sides asked in the same cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rr_pri <= PRI_READ;
    end else if ((state == IDLE) && rd_req_valid && wr_req_valid) begin
      rr_pri <= (rr_pri == PRI_READ) ? PRI_WRITE : PRI_READ;
    end
  end

  // Word index, beat counter and sticky last-marker error.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx  <= '0;
      beat <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (rd_accept) begin
            // Beat 0 is read out at accept, so idx already points at beat 1.
            idx <= rd_req_idx + IDX_W'(1);
          end else if (wr_accept) begin
            idx <= wr_req_idx;
            err <= 1'b0;
          end
        end
        RD_BURST: begin
          if (rd_beat_hs) begin
            if (rd_at_last) begin
              beat <= '0;
            end else begin
              idx  <= idx + IDX_W'(1);
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        WR_BURST: begin
          if (wr_beat_hs) begin
            idx  <= idx + IDX_W'(1);
            beat <= wr_at_last ? '0 : beat + BEAT_W'(1);
            if (wr_data_last != wr_at_last) begin
              err <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (wr_resp_ready) begin
            err <= 1'b0;
          end
        end
        default: begin
          beat <= '0;
        end
      endcase
    end
  end

  // Registered read-beat output: load on accept, advance on each handshake.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      rd_data_last  <= 1'b0;
    end else if ((state == IDLE) && rd_accept) begin
      rd_data_valid <= 1'b1;
      rd_data       <= mem_rdata;
      rd_data_last  <= RD_SINGLE_BEAT;
    end else if ((state == RD_BURST) && rd_beat_hs) begin
      if (rd_at_last) begin
        rd_data_valid <= 1'b0;
        rd_data_last  <= 1'b0;
      end else begin
        rd_data       <= mem_rdata;
        rd_data_last  <= ((beat + BEAT_W'(1)) == RD_LAST_BEAT);
      end
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder. Expected read beats come from a
// bench-side word model and are queued when a read request is issued, then
// popped as the responder presents beats.
module tb_burst_mem_responder;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NW = 128;
  localparam int RL = 8;
  localparam int WL = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr = '0;
  logic          rd_data_valid;
  logic          rd_data_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_data_last;
  logic          wr_req_valid = 1'b0;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr = '0;
  logic          wr_data_valid = 1'b0;
  logic          wr_data_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_data_last = 1'b0;
  logic          wr_resp_valid;
  logic          wr_resp_ready = 1'b0;
  logic          wr_resp_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] model [NW];
  int            tests = 0;
  int            fails = 0;

  burst_mem_responder #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .NUM_WORDS       (NW),
    .READ_BURST_LEN  (RL),
    .WRITE_BURST_LEN (WL),
    .INIT_FILE       ("")
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_data_valid (rd_data_valid),
    .rd_data_ready (rd_data_ready),
    .rd_data       (rd_data),
    .rd_data_last  (rd_data_last),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_data       (wr_data),
    .wr_data_last  (wr_data_last),
    .wr_resp_valid (wr_resp_valid),
    .wr_resp_ready (wr_resp_ready),
    .wr_resp_err   (wr_resp_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a >> 2) % NW);
  endfunction

  task automatic push_read(input logic [AW-1:0] addr);
    beat_t e;
    int    i;
    i = widx(addr);
    for (int b = 0; b < RL; b++) begin
      e.data = model[i];
      e.last = (b == RL - 1);
      sb.push_back(e);
      i = (i + 1) % NW;
    end
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_rd_req_ready"},  {31'd0, rd_req_ready},  32'd0);
    check({tag, "_rd_data_valid"}, {31'd0, rd_data_valid}, 32'd0);
    check({tag, "_rd_data"},       rd_data,                32'd0);
    check({tag, "_rd_data_last"},  {31'd0, rd_data_last},  32'd0);
    check({tag, "_wr_req_ready"},  {31'd0, wr_req_ready},  32'd0);
    check({tag, "_wr_data_ready"}, {31'd0, wr_data_ready}, 32'd0);
    check({tag, "_wr_resp_valid"}, {31'd0, wr_resp_valid}, 32'd0);
    check({tag, "_wr_resp_err"},   {31'd0, wr_resp_err},   32'd0);
  endtask

  task automatic read_req(input logic [AW-1:0] addr);
    @(negedge sys_clk);
    rd_req_valid = 1'b1;
    rd_req_addr  = addr;
    #1;
    check("rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
    check("rd_valid_before_accept", {31'd0, rd_data_valid}, 32'd0);
    push_read(addr);
    @(negedge sys_clk);
    rd_req_valid = 1'b0;
  endtask

  task automatic write_req(input logic [AW-1:0] addr);
    @(negedge sys_clk);
    wr_req_valid = 1'b1;
    wr_req_addr  = addr;
    #1;
    check("wr_req_ready", {31'd0, wr_req_ready}, 32'd1);
    @(negedge sys_clk);
    wr_req_valid = 1'b0;
  endtask

  // Both sides request together; exp_read selects which grant is required.
  task automatic arb_req(input logic [AW-1:0] raddr, input logic [AW-1:0] waddr,
                         input logic exp_read);
    @(negedge sys_clk);
    rd_req_valid = 1'b1;
    rd_req_addr  = raddr;
    wr_req_valid = 1'b1;
    wr_req_addr  = waddr;
    #1;
    check("arb_rd_grant", {31'd0, rd_req_ready}, {31'd0, exp_read});
    check("arb_wr_grant", {31'd0, wr_req_ready}, {31'd0, ~exp_read});
    if (exp_read) push_read(raddr);
    @(negedge sys_clk);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
  endtask

  // Starts at the negedge after write acceptance; last_pos is the 0-based
  // beat on which wr_data_last is driven.
  task automatic write_body(input logic [AW-1:0] addr, input logic [DW-1:0] base,
                            input int last_pos);
    logic err_exp;
    int   i;
    err_exp = 1'b0;
    i = widx(addr);
    for (int b = 0; b < WL; b++) begin
      wr_data_valid = 1'b1;
      wr_data       = base + DW'(b);
      wr_data_last  = (b == last_pos);
      #1;
      check("wr_data_ready", {31'd0, wr_data_ready}, 32'd1);
      if (wr_data_last != (b == WL - 1)) err_exp = 1'b1;
      model[i] = wr_data;
      i = (i + 1) % NW;
      @(negedge sys_clk);
    end
    wr_data_valid = 1'b0;
    wr_data_last  = 1'b0;
    #1;
    check("wr_burst_ended", {31'd0, wr_data_ready}, 32'd0);
    check("wr_resp_valid",  {31'd0, wr_resp_valid}, 32'd1);
    check("wr_resp_err",    {31'd0, wr_resp_err},   {31'd0, err_exp});
    @(negedge sys_clk);
    check("wr_resp_held",   {31'd0, wr_resp_valid}, 32'd1);
    wr_resp_ready = 1'b1;
    @(negedge sys_clk);
    wr_resp_ready = 1'b0;
    #1;
    check("wr_resp_done",   {31'd0, wr_resp_valid}, 32'd0);
    check("wr_resp_err_clr",{31'd0, wr_resp_err},   32'd0);
  endtask

  // Consumes nbeats beats. mode 0: always ready; mode 1: ready 1,0,0,1,0,0...
  task automatic read_body(input int mode, input int nbeats, input int exp_cycles,
                           input logic exp_valid_after);
    int            cyc;
    int            beats;
    logic          rdy;
    logic          held;
    logic [DW-1:0] held_data;
    beat_t         e;
    cyc   = 0;
    beats = 0;
    held  = 1'b0;
    held_data = '0;
    check("rd_first_valid", {31'd0, rd_data_valid}, 32'd1);
    while (beats < nbeats && sb.size() > 0 && cyc < 64) begin
      if (held) check("rd_hold_data", rd_data, held_data);
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      rd_data_ready = rdy;
      if (!rd_data_valid) begin
        check("rd_valid_in_burst", {31'd0, rd_data_valid}, 32'd1);
      end else if (rdy) begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_data_last", {31'd0, rd_data_last}, {31'd0, e.last});
        beats++;
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_data = rd_data;
      end
      @(negedge sys_clk);
      cyc++;
    end
    rd_data_ready = 1'b0;
    check("rd_beats_taken", beats, nbeats);
    check("rd_cycles", cyc, exp_cycles);
    check("rd_valid_after", {31'd0, rd_data_valid}, {31'd0, exp_valid_after});
  endtask

  initial begin
    // Reset values while sys_rst is held.
    @(negedge sys_clk);
    check_outputs_idle("reset");
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Preload: word k = k for 0..15, and words 120..127 = 0x178..0x17F.
    write_req(32'h00);  write_body(32'h00, 32'h0, WL - 1);
    write_req(32'h20);  write_body(32'h20, 32'h8, WL - 1);
    write_req(32'h1E0); write_body(32'h1E0, 32'h178, WL - 1);

    // Plain read: beats 4..11, one per cycle.
    read_req(32'h10);
    read_body(0, RL, RL, 1'b0);

    // Overwrite, then read back the new data.
    write_req(32'h20); write_body(32'h20, 32'hA0, WL - 1);
    read_req(32'h20);
    read_body(0, RL, RL, 1'b0);

    // Wrap at the array end: indices 124..127, 0..3.
    read_req(32'h1F0);
    read_body(0, RL, RL, 1'b0);

    // Back-pressure: ready 1,0,0,1,... gives 3 cycles per beat after the first.
    read_req(32'h10);
    read_body(1, RL, 3 * (RL - 1) + 1, 1'b0);

    // Collisions: READ, WRITE, READ.
    arb_req(32'h00, 32'h60, 1'b1);
    read_body(0, RL, RL, 1'b0);
    arb_req(32'h00, 32'h60, 1'b0);
    write_body(32'h60, 32'hD0, WL - 1);
    arb_req(32'h60, 32'h60, 1'b1);
    read_body(0, RL, RL, 1'b0);

    // Misplaced last marker on the third beat still takes a full burst.
    write_req(32'h40); write_body(32'h40, 32'hC0, 2);

    // Reset in the middle of a read burst.
    read_req(32'h10);
    read_body(0, 3, 3, 1'b1);
    sys_rst = 1'b1;
    #1;
    check_outputs_idle("midrst");
    sb.delete();
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Array survives the reset.
    read_req(32'h10);
    read_body(0, RL, RL, 1'b0);
    read_req(32'h40);
    read_body(0, RL, RL, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
